// File: rtl/fpcvt_seq.sv
// Sequential two's-complement to (sign, exponent, significand) converter with valid/ready handshakes.
// Define FPCVT_ROUND_EN for round-to-nearest (ties up); otherwise the significand is truncated.
`timescale 1ns/1ps
module fpcvt_seq #(
    parameter int IN_W   = 12,
    parameter int EXP_W  = 3,
    parameter int MANT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_s,
    output logic [EXP_W-1:0]  out_e,
    output logic [MANT_W-1:0] out_f,
    output logic              out_sat
);
    localparam int M    = IN_W - 1;
    localparam int EMAX = 2**EXP_W - 1;

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t             state_reg;
    logic [M-1:0]       mag_reg;
    logic [EXP_W-1:0]   cnt_reg;
    logic               sign_reg;
    logic               neg_max_reg;

    logic [IN_W-1:0]    neg_data;
    logic               is_neg_max;
    logic [M-1:0]       abs_mag;
    logic [MANT_W-1:0]  f_trunc;
    logic [MANT_W-1:0]  f_next;
    logic [EXP_W-1:0]   e_next;
    logic               sat_next;

    // The most negative sample has no M-bit magnitude; clamp it to all ones.
    assign neg_data   = -in_data;
    assign is_neg_max = (in_data == {1'b1, {M{1'b0}}});
    assign abs_mag    = is_neg_max       ? {M{1'b1}} :
                        in_data[IN_W-1]  ? neg_data[M-1:0] : in_data[M-1:0];
    assign f_trunc    = mag_reg[M-1 -: MANT_W];

`ifdef FPCVT_ROUND_EN
    logic               rnd_bit;
    logic [EXP_W:0]     e_base;
    logic [EXP_W:0]     e_round;
    logic [MANT_W:0]    f_sum;
    logic [MANT_W-1:0]  f_mid;

    assign rnd_bit = mag_reg[M-MANT_W-1];
    assign e_base  = (EXP_W+1)'(EMAX) - {1'b0, cnt_reg};
    assign f_sum   = {1'b0, f_trunc} + {{MANT_W{1'b0}}, rnd_bit};

    always_comb begin
        f_mid   = f_sum[MANT_W-1:0];
        e_round = e_base;
        // A carry out of the significand renormalises to 1.000 one exponent up.
        if (f_sum[MANT_W]) begin
            f_mid   = {1'b1, {(MANT_W-1){1'b0}}};
            e_round = e_base + 1'b1;
        end
        f_next   = f_mid;
        e_next   = e_round[EXP_W-1:0];
        sat_next = neg_max_reg;
        if (e_round > (EXP_W+1)'(EMAX)) begin
            f_next   = {MANT_W{1'b1}};
            e_next   = EXP_W'(EMAX);
            sat_next = 1'b1;
        end
    end
`else
    always_comb begin
        f_next   = f_trunc;
        e_next   = EXP_W'(EMAX) - cnt_reg;
        sat_next = neg_max_reg;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_s       <= 1'b0;
            out_e       <= '0;
            out_f       <= '0;
            out_sat     <= 1'b0;
            mag_reg     <= '0;
            cnt_reg     <= '0;
            sign_reg    <= 1'b0;
            neg_max_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        sign_reg    <= in_data[IN_W-1];
                        mag_reg     <= abs_mag;
                        neg_max_reg <= is_neg_max;
                        cnt_reg     <= '0;
                        in_ready    <= 1'b0;
                        state_reg   <= NORM;
                    end
                end
                NORM: begin
                    // Shifting stops at EMAX so small values land in the E == 0 range.
                    if (mag_reg[M-1] || cnt_reg == EXP_W'(EMAX)) begin
                        state_reg <= ROUND;
                    end else begin
                        mag_reg <= {mag_reg[M-2:0], 1'b0};
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ROUND: begin
                    out_s     <= sign_reg;
                    out_e     <= e_next;
                    out_f     <= f_next;
                    out_sat   <= sat_next;
                    out_valid <= 1'b1;
                    state_reg <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fpcvt_seq.sv
// Bench for fpcvt_seq: directed corner cases plus random samples against a value = F * 2^E model.
`timescale 1ns/1ps
module tb_fpcvt_seq;
    localparam int IN_W   = 12;
    localparam int EXP_W  = 3;
    localparam int MANT_W = 4;
    localparam int EMAX   = 2**EXP_W - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_s;
    logic [EXP_W-1:0]  out_e;
    logic [MANT_W-1:0] out_f;
    logic              out_sat;

    int checks_total  = 0;
    int checks_passed = 0;

    typedef struct {
        logic s;
        int   e;
        int   f;
        logic sat;
        int   k;
    } res_t;

    always #5 clk = ~clk;

    fpcvt_seq #(.IN_W(IN_W), .EXP_W(EXP_W), .MANT_W(MANT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s(out_s), .out_e(out_e), .out_f(out_f), .out_sat(out_sat)
    );

    // Pick the smallest exponent whose significand fits MANT_W bits, then round.
    function automatic res_t model(input logic [IN_W-1:0] x);
        res_t m;
        int   v;
        int   r;
        m.s   = x[IN_W-1];
        m.sat = 1'b0;
        v     = int'(signed'(x));
        if (v < 0) v = -v;
        if (v == 2**(IN_W-1)) begin
            v     = 2**(IN_W-1) - 1;
            m.sat = 1'b1;
        end
        m.e = 0;
        while (m.e < EMAX && v >= 2**(MANT_W + m.e)) m.e++;
        m.k = EMAX - m.e;
        m.f = v >> m.e;
        r   = (m.e > 0) ? ((v >> (m.e - 1)) & 1) : 0;
`ifdef FPCVT_ROUND_EN
        m.f = m.f + r;
        if (m.f == 2**MANT_W) begin
            m.f = 2**(MANT_W-1);
            m.e = m.e + 1;
        end
        if (m.e > EMAX) begin
            m.e   = EMAX;
            m.f   = 2**MANT_W - 1;
            m.sat = 1'b1;
        end
`else
        if (r > 1) m.f = 0;
`endif
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input res_t m);
        check({tag, "_s"},   32'(out_s),   32'(m.s));
        check({tag, "_e"},   32'(out_e),   m.e);
        check({tag, "_f"},   32'(out_f),   m.f);
        check({tag, "_sat"}, 32'(out_sat), 32'(m.sat));
    endtask

    // Called just after the accepting edge: latency, result, back-pressure hold, handshake.
    task automatic finish_txn(input logic [IN_W-1:0] x, input int hold);
        res_t m;
        int   lat;
        m   = model(x);
        lat = 0;
        check("busy_after_accept", 32'(in_ready), 0);
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("latency", lat, m.k + 2);
        check_result("result", m);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", 32'(out_valid), 1);
            check("hold_ready", 32'(in_ready), 0);
            check_result("hold", m);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_hs_valid", 32'(out_valid), 0);
        check("post_hs_ready", 32'(in_ready), 1);
        $display("txn in=%h s=%0d e=%0d f=%0d sat=%0d lat=%0d hold=%0d",
                 x, m.s, m.e, m.f, m.sat, lat, hold);
    endtask

    task automatic run(input logic [IN_W-1:0] x, input int hold);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        check("ready_wait", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = x;
        tick();
        in_valid = 1'b0;
        in_data  = IN_W'($urandom);
        finish_txn(x, hold);
    endtask

    initial begin
        int   seen;
        res_t m;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_ready", 32'(in_ready), 1);
        check("rst_valid", 32'(out_valid), 0);
        check_result("rst", model('0));

        // Directed corners: zero, rounding carry, extremes, negatives.
        run(12'd0, 0);
        run(12'd125, 0);
        run(12'd2047, 1);
        run(12'h800, 0);
        run(12'hF7F, 0);
        run(12'hFFF, 0);

        // Back-pressure with a second sample waiting on in_valid.
        in_valid = 1'b1;
        in_data  = 12'd2047;
        tick();
        in_data  = 12'd16;
        m    = model(12'd2047);
        seen = 0;
        while (!out_valid && seen < 20) begin
            check("bp_busy_ready", 32'(in_ready), 0);
            tick();
            seen++;
        end
        check("bp_latency", seen, m.k + 2);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(out_valid), 1);
            check("bp_ready", 32'(in_ready), 0);
            check_result("bp_hold", m);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_ready_after_hs", 32'(in_ready), 1);
        check("bp_valid_after_hs", 32'(out_valid), 0);
        tick();
        in_valid = 1'b0;
        finish_txn(12'd16, 0);

        // Reset while normalising a small value.
        in_valid = 1'b1;
        in_data  = 12'd1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_ready", 32'(in_ready), 1);
        check("midrst_valid", 32'(out_valid), 0);
        check_result("midrst", model('0));
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen++;
            tick();
        end
        check("midrst_no_pulse", seen, 0);
        run(12'd16, 0);

        // Random samples with random back-pressure.
        for (int i = 0; i < 40; i++) begin
            run(IN_W'($urandom), int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
